// File: rtl/instr_loader_encoder_pkg.sv
// Shared types and constants for the RV32I instruction loader/encoder:
// micro-op classes, opcodes identical to the decoder's, funct fields,
// the loader state enum and the field-packing function.
package instr_loader_encoder_pkg;

  typedef enum logic [3:0] {
    UOP_LOAD   = 4'd0,
    UOP_OP_IMM = 4'd1,
    UOP_STORE  = 4'd2,
    UOP_AUIPC  = 4'd3,
    UOP_LUI    = 4'd4,
    UOP_JAL    = 4'd5,
    UOP_JALR   = 4'd6,
    UOP_BRANCH = 4'd7,
    UOP_OP     = 4'd8
  } uop_class_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;

  localparam logic [2:0] FUNCT3_JALR = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Packs one micro-op into an RV32I word and flags combinations the
  // decoder would reject (those are dropped by the loader).
  function automatic enc_t encode_uop(
    input logic [3:0]  cls,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] imm
  );
    enc_t       r;
    logic [6:0] f7;
    r.legal = 1'b1;
    r.word  = '0;
    f7      = alt ? FUNCT7_ALT : FUNCT7_BASE;
    case (cls)
      UOP_LOAD: begin
        r.word  = {imm[11:0], rs1, f3, rd, OPCODE_LOAD};
        r.legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      UOP_OP_IMM: begin
        if (f3 == FUNCT3_SLL || f3 == FUNCT3_SR)
          r.word = {f7, imm[4:0], rs1, f3, rd, OPCODE_OP_IMM};
        else
          r.word = {imm[11:0], rs1, f3, rd, OPCODE_OP_IMM};
        r.legal = !(alt && f3 != FUNCT3_SR);
      end
      UOP_STORE: begin
        r.word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPCODE_STORE};
        r.legal = (f3 <= 3'b010);
      end
      UOP_AUIPC: r.word = {imm[31:12], rd, OPCODE_AUIPC};
      UOP_LUI:   r.word = {imm[31:12], rd, OPCODE_LUI};
      UOP_JAL: begin
        r.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
        r.legal = !imm[0];
      end
      UOP_JALR: r.word = {imm[11:0], rs1, FUNCT3_JALR, rd, OPCODE_JALR};
      UOP_BRANCH: begin
        r.word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPCODE_BRANCH};
        r.legal = !(f3 == 3'b010 || f3 == 3'b011 || imm[0]);
      end
      UOP_OP: begin
        r.word  = {f7, rs2, rs1, f3, rd, OPCODE_OP};
        r.legal = !(alt && f3 != FUNCT3_ADD && f3 != FUNCT3_SR);
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_loader_encoder_fifo.sv
// Synchronous FIFO holding encoded instruction words between the
// micro-op port and the instruction-memory write port.
module instr_fifo
  import instr_loader_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes all buffered entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/instr_loader_encoder.sv
// RV32I instruction loader: packs micro-ops into instruction words,
// buffers them and writes them sequentially into instruction memory.
//
// Handshakes: a micro-op transfers on a rising edge where i_uop_vld and
// o_uop_rdy are both high; o_uop_rdy never depends on i_uop_vld. A memory
// write completes on a rising edge where o_imem_wren and i_imem_rdy are
// both high; until then o_imem_addr and o_imem_wdata hold their value.
module instr_loader_encoder
  import instr_loader_encoder_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_uop_vld,
  output logic              o_uop_rdy,
  input  logic [3:0]        i_uop_class,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic              i_alt,
  input  logic [31:0]       i_imm,
  input  logic              i_last,
  output logic              o_imem_wren,
  input  logic              i_imem_rdy,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-2:0] o_count,
  output state_e            o_state
);

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-2:0] count;
  logic              err;

  enc_t              enc;
  logic              uop_fire;
  logic              push;
  logic              pop;
  logic [31:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   addr_sum;

  assign enc = encode_uop(i_uop_class, i_rd, i_rs1, i_rs2, i_funct3, i_alt, i_imm);

  // Ready follows current occupancy only, so a pop in the same cycle
  // does not open a slot early.
  assign o_uop_rdy = (state == ST_RUN) && !fifo_full;
  assign uop_fire  = i_uop_vld && o_uop_rdy;
  assign push      = uop_fire && enc.legal;
  assign pop       = o_imem_wren && i_imem_rdy;
  assign addr_sum  = {1'b0, addr} + (ADDR_W+1)'(4);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (enc.word),
    .i_pop   (pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_imem_wren  = !fifo_empty;
  assign o_imem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign o_imem_addr  = addr;
  assign o_count      = count;
  assign o_err        = err;
  assign o_busy       = (state != ST_IDLE);
  assign o_done       = (state == ST_DONE);
  assign o_state      = state;

  // Session FSM plus write address, word count and sticky error tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      addr  <= BASE_ADDR;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (pop) begin
        addr  <= addr_sum[ADDR_W-1:0];
        count <= count + (ADDR_W-1)'(1);
        if (addr_sum[ADDR_W]) err <= 1'b1;
      end
      if (uop_fire && !enc.legal) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_RUN;
            addr  <= BASE_ADDR;
            count <= '0;
            err   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (uop_fire && i_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Empty FIFO means no write is left on the port.
          if (fifo_empty) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
